// File: rtl/button_debounce_pkg.sv
// Shared state encoding and default debounce lengths for the two-button input conditioner.
package button_debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ARM_HI = 2'b01,
    HIGH   = 2'b11,
    ARM_LO = 2'b10
  } db_state_e;

  localparam int DEBOUNCE_CYCLES_SIM   = 4;
  localparam int DEBOUNCE_CYCLES_BOARD = 50000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchroniser, qualification FSM, counter and registered outputs.
//   state  | meaning
//   IDLE   | stable 0
//   ARM_HI | candidate 1, counting
//   HIGH   | stable 1
//   ARM_LO | candidate 0, counting
module debounce_channel
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1, s;
  db_state_e        state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             level_n, rise_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s     <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1    <= btn_raw;
      s     <= s1;
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      rise  <= rise_n;
    end
  end

  // Counter saturates at the terminal count by construction: reaching it always leaves the ARM state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level;
    rise_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_n = ARM_HI;
          cnt_n   = '0;
        end
      end
      ARM_HI: begin
        if (!s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == CNT_TC) begin
          state_n = HIGH;
          level_n = 1'b1;
          rise_n  = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s) begin
          state_n = ARM_LO;
          cnt_n   = '0;
        end
      end
      ARM_LO: begin
        if (s) begin
          state_n = HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_TC) begin
          state_n = IDLE;
          level_n = 1'b0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_debounce_pair.sv
// Two independent debounce channels feeding the two-button LED FSM; wiring only.
module button_debounce_pair
  import button_debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_SIM,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_a_raw,
  input  logic btn_b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic b_rise
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_a (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_a_raw),
    .level  (a),
    .rise   (a_rise)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_chan_b (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_b_raw),
    .level  (b),
    .rise   (b_rise)
  );

endmodule

// File: tb/tb_button_debounce_pair.sv
// Directed bench: a run-length reference model pushes expected outputs per edge; DUT outputs are popped and compared.
module tb_button_debounce_pair;
  import button_debounce_pkg::*;

  localparam int D = DEBOUNCE_CYCLES_SIM;

  logic clk = 1'b0;
  logic rst, btn_a_raw, btn_b_raw;
  logic a, b, a_rise, b_rise;

  always #5 clk = ~clk;

  button_debounce_pair #(.DEBOUNCE_CYCLES(D), .CNT_W(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_a_raw(btn_a_raw),
    .btn_b_raw(btn_b_raw),
    .a        (a),
    .b        (b),
    .a_rise   (a_rise),
    .b_rise   (b_rise)
  );

  logic [3:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference: level flips once the synchronised input has disagreed with it for D+1 consecutive edges.
  logic m_r1[2], m_r2[2], m_lvl[2], m_rise[2];
  int   m_run[2];
  int   edge_n, first_a, a_rise_cnt, b_hi_cnt;

  task automatic model_edge(input logic r, input logic ra, input logic rb);
    logic raw[2];
    raw[0] = ra;
    raw[1] = rb;
    for (int c = 0; c < 2; c++) begin
      if (r) begin
        m_r1[c] = 1'b0; m_r2[c] = 1'b0; m_lvl[c] = 1'b0; m_rise[c] = 1'b0; m_run[c] = 0;
      end else begin
        m_rise[c] = 1'b0;
        if (m_r2[c] != m_lvl[c]) begin
          m_run[c]++;
          if (m_run[c] == D + 1) begin
            m_lvl[c]  = ~m_lvl[c];
            m_rise[c] = m_lvl[c];
            m_run[c]  = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_r2[c] = m_r1[c];
        m_r1[c] = raw[c];
      end
    end
  endtask

  task automatic cycle(input string tag, input logic r, input logic ra, input logic rb);
    logic [3:0] got, exp;
    rst = r; btn_a_raw = ra; btn_b_raw = rb;
    model_edge(r, ra, rb);
    exp_q.push_back({m_lvl[0], m_lvl[1], m_rise[0], m_rise[1]});
    @(posedge clk);
    #1;
    edge_n++;
    got = {a, b, a_rise, b_rise};
    exp = exp_q.pop_front();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge %0d observed {a,b,a_rise,b_rise}=%b expected %b", tag, edge_n, got, exp);
    end
    if (a === 1'b1 && first_a < 0) first_a = edge_n;
    if (a_rise === 1'b1) a_rise_cnt++;
    if (b !== 1'b0 || b_rise !== 1'b0) b_hi_cnt++;
  endtask

  task automatic run(input string tag, input logic r, input logic ra, input logic rb, input int n);
    for (int i = 0; i < n; i++) cycle(tag, r, ra, rb);
  endtask

  task automatic mark();
    edge_n = 0; first_a = -1; a_rise_cnt = 0; b_hi_cnt = 0;
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got == exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    mark();
    // 1: reset hold with both buttons pressed, then re-qualification after release
    run("reset_hold", 1'b1, 1'b1, 1'b1, 3);
    mark();
    run("post_reset", 1'b0, 1'b1, 1'b1, 12);
    check_int("post_reset_latency", first_a, D + 3);
    check_int("post_reset_rise_cnt", a_rise_cnt, 1);
    run("release_both", 1'b0, 1'b0, 1'b0, 10);

    // 2: clean press on A only
    mark();
    run("press_a", 1'b0, 1'b1, 1'b0, 20);
    check_int("press_a_latency", first_a, D + 3);
    check_int("press_a_rise_cnt", a_rise_cnt, 1);
    check_int("press_a_b_quiet", b_hi_cnt, 0);
    run("release_a", 1'b0, 1'b0, 1'b0, 10);

    // 3: glitch boundary, D edges rejected, D+1 accepted
    mark();
    run("glitch_short", 1'b0, 1'b1, 1'b0, D);
    run("glitch_short_lo", 1'b0, 1'b0, 1'b0, 12);
    check_int("glitch_short_reject", first_a, -1);
    mark();
    run("glitch_min", 1'b0, 1'b1, 1'b0, D + 1);
    run("glitch_min_lo", 1'b0, 1'b0, 1'b0, 3);
    check_int("glitch_min_latency", first_a, D + 3);
    run("glitch_min_settle", 1'b0, 1'b0, 1'b0, 10);

    // 4: release with bounce
    run("hold_a", 1'b0, 1'b1, 1'b0, 10);
    cycle("bounce0", 1'b0, 1'b0, 1'b0);
    cycle("bounce1", 1'b0, 1'b1, 1'b0);
    mark();
    run("bounce_final_lo", 1'b0, 1'b0, 1'b0, 10);
    check_int("bounce_no_rise", a_rise_cnt, 0);

    // 5: simultaneous press
    mark();
    run("simul_press", 1'b0, 1'b1, 1'b1, 10);
    run("simul_release", 1'b0, 1'b0, 1'b0, 10);

    // 6: reset mid ARM_HI
    run("arm_then_rst", 1'b0, 1'b1, 1'b0, 4);
    cycle("mid_rst", 1'b1, 1'b1, 1'b0);
    mark();
    run("after_rst", 1'b0, 1'b1, 1'b0, 10);
    check_int("after_rst_latency", first_a, D + 3);
    run("after_rst_release", 1'b0, 1'b0, 1'b0, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
